// File: rtl/result_display_if.sv
// Handshake and display bus between the comparison unit, result_display and its observers.
// master drives the result and load strobe; slave (result_display) drives status and display.
interface result_display_if;
  logic [7:0]  f;
  logic        load;
  logic        busy;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output f,
    output load,
    input  busy,
    input  bcd,
    input  an,
    input  seg
  );

  modport slave (
    input  f,
    input  load,
    output busy,
    output bcd,
    output an,
    output seg
  );
endinterface

// File: rtl/result_display.sv
// Captures an 8-bit result, converts it to BCD with a sequential double-dabble engine and scans
// it onto a 4-digit common-anode display. Define RESULT_DISPLAY_LZB_EN for leading-zero blanking.
module result_display #(
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic             clk,
  input  logic             rst,
  result_display_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e                  r_state;
  logic [7:0]              r_shreg;
  logic [11:0]             r_work;
  logic [2:0]              r_iter;
  logic                    r_busy;
  logic [11:0]             r_bcd;
  logic [REFRESH_BITS-1:0] r_scan;
  logic [3:0]              r_an;
  logic [6:0]              r_seg;

  logic [11:0] w_adj;
  logic [19:0] w_shift;
  logic [1:0]  w_slot;
  logic        w_blank_hund;
  logic        w_blank_tens;
  logic [3:0]  w_an_d;
  logic [6:0]  w_seg_d;

  // Nibbles >= 5 get +3 so the following doubling carries correctly into the next decade.
  function automatic logic [11:0] add3_nibbles(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_adj   = add3_nibbles(r_work);
  assign w_shift = {w_adj, r_shreg} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_work  <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.load) begin
            r_shreg <= bus.f;
            r_work  <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= StConv;
          end
        end
        StConv: begin
          // load is deliberately not looked at here: no queueing, no restart.
          r_work  <= w_shift[19:8];
          r_shreg <= w_shift[7:0];
          r_iter  <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_bcd   <= w_shift[19:8];
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_slot = r_scan[REFRESH_BITS-1 -: 2];

`ifdef RESULT_DISPLAY_LZB_EN
  assign w_blank_hund = (r_bcd[11:8] == 4'd0);
  assign w_blank_tens = w_blank_hund && (r_bcd[7:4] == 4'd0);
`else
  assign w_blank_hund = 1'b0;
  assign w_blank_tens = 1'b0;
`endif

  // Slot 3 is a dark slot so each real digit keeps a 1/4 duty cycle.
  always_comb begin
    w_an_d  = 4'b1111;
    w_seg_d = 7'b1111111;
    unique case (w_slot)
      2'd0: begin
        w_an_d  = 4'b1110;
        w_seg_d = seg_of(r_bcd[3:0]);
      end
      2'd1: begin
        w_an_d  = 4'b1101;
        w_seg_d = w_blank_tens ? 7'b1111111 : seg_of(r_bcd[7:4]);
      end
      2'd2: begin
        w_an_d  = 4'b1011;
        w_seg_d = w_blank_hund ? 7'b1111111 : seg_of(r_bcd[11:8]);
      end
      default: begin
        w_an_d  = 4'b1111;
        w_seg_d = 7'b1111111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
      r_an   <= 4'b1111;
      r_seg  <= 7'b1111111;
    end else begin
      r_scan <= r_scan + REFRESH_BITS'(1);
      r_an   <= w_an_d;
      r_seg  <= w_seg_d;
    end
  end

  assign bus.busy = r_busy;
  assign bus.bcd  = r_bcd;
  assign bus.an   = r_an;
  assign bus.seg  = r_seg;

endmodule

// File: tb/tb_result_display.sv
// Randomized self-checking bench for result_display: BCD values from decimal arithmetic,
// display from a slot/cycle model with a segment lookup table.
module tb_result_display;

  localparam int unsigned RB = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  result_display_if bus ();

  result_display #(.REFRESH_BITS(RB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [10];
  int         exp_val;
  int         m_scan;
  int         m_prev_scan;
  bit         m_prev_rst;

  // Model of what the scan position was when the display registers last loaded.
  initial begin
    m_scan      = 0;
    m_prev_scan = 0;
    m_prev_rst  = 1'b1;
  end
  always @(posedge clk) begin
    m_prev_rst  = rst;
    m_prev_scan = m_scan;
    m_scan      = rst ? 0 : (m_scan + 1) % (1 << RB);
  end

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_disp(input string tag);
    int slot;
    int d;
    bit blank;
    logic [3:0] ean;
    logic [6:0] eseg;
    slot  = (m_prev_scan >> (RB - 2)) & 3;
    blank = 1'b0;
    d     = 0;
    if (m_prev_rst || slot == 3) begin
      ean  = 4'b1111;
      eseg = 7'b1111111;
    end else begin
      ean = ~(4'b0001 << slot);
      if (slot == 0) d = exp_val % 10;
      else if (slot == 1) d = (exp_val / 10) % 10;
      else d = exp_val / 100;
`ifdef RESULT_DISPLAY_LZB_EN
      if (slot == 2 && exp_val < 100) blank = 1'b1;
      if (slot == 1 && exp_val < 10) blank = 1'b1;
`endif
      eseg = blank ? 7'b1111111 : segtab[d];
    end
    chk({tag, "_an"}, 32'(bus.an), 32'(ean));
    chk({tag, "_seg"}, 32'(bus.seg), 32'(eseg));
  endtask

  task automatic disp_window(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_disp(tag);
    end
  endtask

  task automatic start(input int fv);
    bus.f    = 8'(fv);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Called with `pre` busy cycles already elapsed since the load edge.
  task automatic finish_conv(input string tag, input int v, input int pre);
    int cnt;
    int guard;
    cnt   = pre;
    guard = 0;
    chk({tag, "_busy_up"}, 32'(bus.busy), 32'd1);
    while (bus.busy === 1'b1 && guard < 30) begin
      chk({tag, "_held"}, 32'(bus.bcd), 32'(to_bcd(exp_val)));
      @(negedge clk);
      guard++;
      if (bus.busy === 1'b1) cnt++;
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd8);
    chk({tag, "_bcd"}, 32'(bus.bcd), 32'(to_bcd(v)));
    exp_val = v;
  endtask

  initial begin
    int v;
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    checks   = 0;
    errors   = 0;
    exp_val  = 0;
    rst      = 1'b1;
    bus.f    = 8'd0;
    bus.load = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'h000);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", 32'(bus.an), 32'b1110);
    chk("first_seg", 32'(bus.seg), 32'b1000000);
    disp_window("idle0", 8);

    // Maximum input
    start(255);
    finish_conv("ff", 255, 1);
    disp_window("ff_disp", 16);

    // Load during conversion is ignored
    start(7);
    @(negedge clk);
    bus.f    = 8'd100;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    finish_conv("midload", 7, 3);
    disp_window("d7_disp", 16);

    // Reset mid-conversion aborts
    start(15);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_val = 0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_bcd", 32'(bus.bcd), 32'h000);
    disp_window("abort_disp", 4);
    start(15);
    finish_conv("after_abort", 15, 1);

    // Back-to-back: second load in the first idle cycle
    start(9);
    finish_conv("b2b_a", 9, 1);
    start(10);
    finish_conv("b2b_b", 10, 1);
    disp_window("d10_disp", 16);

    // Boundary and random values
    start(0);
    finish_conv("zero", 0, 1);
    disp_window("zero_disp", 16);
    start(100);
    finish_conv("hundred", 100, 1);
    disp_window("h_disp", 16);
    for (int n = 0; n < 20; n++) begin
      v = int'($urandom_range(0, 255));
      start(v);
      finish_conv("rand", v, 1);
      disp_window("rand_disp", 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
